// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary-to-BCD converter, one input bit
// per clock. Produces packed BCD digits plus a leading-zero blank mask for the
// seven-segment scan driver. Values above the largest displayable number are
// saturated to all nines and flagged with overflow.
//
// Handshake: start is only looked at while idle (busy = 0). The edge that sees
// start = 1 in IDLE accepts it and captures bin_in; starts seen while busy are
// dropped. done is a one-cycle pulse in the first idle cycle after a
// conversion, and start may be asserted in that same cycle to run
// back-to-back conversions.
module bin2bcd_seq #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(pow10(DIGITS) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t                   state;
  logic [BCD_W+BIN_W-1:0]   sreg;      // {bcd digits, remaining binary bits}
  logic [CNT_W-1:0]         cnt;
  logic                     ovf_pend;

  logic [BCD_W-1:0]         bcd_cur;
  logic [BCD_W-1:0]         bcd_adj;
  logic [DIGITS-1:0]        mask_next;
  logic                     all_zero;

  assign bcd_cur = sreg[BCD_W+BIN_W-1 -: BCD_W];

  // Add 3 to every digit >= 5 ahead of the shift; digits never exceed 9, so
  // the 4-bit add cannot carry into the next digit.
  always_comb begin
    bcd_adj = bcd_cur;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_cur[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_cur[4*i +: 4] + 4'd3;
    end
  end

  // Blank digit i when it and every more significant digit are zero; digit 0
  // is never blanked so a zero value still shows "0".
  always_comb begin
    mask_next = '0;
    all_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero     = all_zero & (bcd_cur[4*i +: 4] == 4'd0);
      mask_next[i] = all_zero;
    end
  end

  // Control FSM with registered outputs, shift register and bit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      ovf_pend   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      bcd_out    <= '0;
      blank_mask <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg     <= {{BCD_W{1'b0}}, (bin_in > MAX_VAL) ? MAX_VAL : bin_in};
            cnt      <= '0;
            ovf_pend <= (bin_in > MAX_VAL);
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sreg <= {bcd_adj, sreg[BIN_W-1:0]} << 1;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_W - 1))
            state <= LATCH;
        end
        LATCH: begin
          bcd_out    <= bcd_cur;
          blank_mask <= mask_next;
          overflow   <= ovf_pend;
          busy       <= 1'b0;
          done       <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed test of bin2bcd_seq with hand-computed results.
module tb_bin2bcd_seq;

  localparam int BIN_W  = 27;
  localparam int DIGITS = 8;
  localparam int LAT    = BIN_W + 1;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [BIN_W-1:0]    bin_in;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   blank_mask;
  logic                overflow;

  int checks = 0;
  int passes = 0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .bcd_out    (bcd_out),
    .blank_mask (blank_mask),
    .overflow   (overflow)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start a conversion, wait for done (bounded), check latency, busy, output
  // hold during the conversion, and the final result. If poke is set, a
  // stray start with bin_in = 42 is pulsed at cycle 10 of the conversion.
  task automatic run_conv(input string tag, input logic [BIN_W-1:0] val,
                          input logic [31:0] exp_bcd, input logic [7:0] exp_mask,
                          input logic exp_ovf, input logic poke);
    logic [31:0] prev_bcd;
    logic        busy_ok;
    logic        hold_ok;
    int          n;
    prev_bcd = bcd_out;
    busy_ok  = 1'b1;
    hold_ok  = 1'b1;
    bin_in   = val;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    bin_in   = BIN_W'($urandom_range(0, 99_999_999));
    n = 0;
    while (n < 100) begin
      if (poke && n == 9) begin
        start  = 1'b1;
        bin_in = BIN_W'(42);
      end
      tick();
      start = 1'b0;
      n++;
      if (done) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (bcd_out !== prev_bcd) hold_ok = 1'b0;
    end
    check({tag, " latency"}, n, LAT);
    check({tag, " busy_during"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " hold"}, {31'd0, hold_ok}, 32'd1);
    check({tag, " busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, " bcd"}, bcd_out, exp_bcd);
    check({tag, " mask"}, {24'd0, blank_mask}, {24'd0, exp_mask});
    check({tag, " ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
  endtask

  initial begin
    int n_done;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();

    check("rst bcd",  bcd_out, 32'h0000_0000);
    check("rst mask", {24'd0, blank_mask}, 32'h0000_00FE);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst ovf",  {31'd0, overflow}, 32'd0);

    run_conv("c12345678", 27'd12_345_678, 32'h1234_5678, 8'h00, 1'b0, 1'b0);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);

    run_conv("c905", 27'd905, 32'h0000_0905, 8'hF8, 1'b0, 1'b0);
    run_conv("c0",   27'd0,   32'h0000_0000, 8'hFE, 1'b0, 1'b0);

    run_conv("c99999999",  27'd99_999_999,  32'h9999_9999, 8'h00, 1'b0, 1'b0);
    run_conv("c100000000", 27'd100_000_000, 32'h9999_9999, 8'h00, 1'b1, 1'b0);
    run_conv("c7",         27'd7,           32'h0000_0007, 8'hFE, 1'b0, 1'b0);

    // Stray start mid-conversion is ignored; start in the done cycle is taken.
    run_conv("c1234_poke", 27'd1234, 32'h0000_1234, 8'hF0, 1'b0, 1'b1);
    run_conv("c42_b2b",    27'd42,   32'h0000_0042, 8'hFC, 1'b0, 1'b0);

    // Leave overflow set, then abort a conversion with reset at shift 15.
    run_conv("cmax27", 27'h7FF_FFFF, 32'h9999_9999, 8'h00, 1'b1, 1'b0);
    tick();
    bin_in = 27'd1234;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort bcd",  bcd_out, 32'h0000_0000);
    check("abort mask", {24'd0, blank_mask}, 32'h0000_00FE);
    check("abort ovf",  {31'd0, overflow}, 32'd0);
    n_done = 0;
    repeat (40) begin
      tick();
      if (done) n_done++;
    end
    check("abort no_done", n_done, 0);

    run_conv("c5_after_abort", 27'd5, 32'h0000_0005, 8'hFE, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter that feeds the 8-digit seven-segment scan driver.
- Takes an unsigned binary value and produces 8 packed BCD digits plus a leading-zero blank mask.
- The scan driver decodes the digits to segment patterns.
- Uses iterative shift-and-add-3 (double dabble), one bit per clock, to keep area small.

Parameters:
- BIN_W, 27, binary input width. Must satisfy 2^BIN_W > 10^DIGITS - 1.
- DIGITS, 8, number of BCD output digits. MAX_VAL = 10^DIGITS - 1 = 99_999_999 at the default.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request conversion of bin_in; sampled only in IDLE.
- bin_in  input  BIN_W  unsigned value to convert; sampled on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd_out, blank_mask and overflow are valid and updated.
- bcd_out  output  4*DIGITS  packed BCD; nibble i = digit i, with digit 0 the least significant.
- blank_mask  output  DIGITS  bit i = 1 means digit i is a leading zero and is to be blanked.
- overflow  output  1  last accepted bin_in exceeded MAX_VAL; result saturated.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values (rst_n = 0 at an edge):
  - state = IDLE; busy = 0; done = 0; overflow = 0.
  - bcd_out = 0; blank_mask = {DIGITS-1{1'b1}, 1'b0}, i.e. 8'hFE, so "0" is displayed.
  - Internal shift register and bit counter cleared.
  - Reset mid-conversion aborts immediately; the partial result is discarded.
- States:
  - IDLE: busy = 0. If start = 1, load the shift register's binary part with min(bin_in, MAX_VAL), clear the BCD part, clear bit counter, capture ovf_pend = (bin_in > MAX_VAL), go to SHIFT.
  - SHIFT: busy = 1. Each cycle, every BCD nibble >= 5 gets +3, then the whole {bcd, bin} register shifts left by 1 and the counter increments. After the BIN_W-th shift, go to LATCH.
  - LATCH: busy = 1. Register bcd_out, blank_mask and overflow = ovf_pend. Go to IDLE with done = 1 in the following cycle.
- Latency:
  - start accepted at edge 0; shifts on edges 1..BIN_W; outputs latched at edge BIN_W+1.
  - done is high for exactly one cycle after edge BIN_W+1, i.e. 28 cycles at default. busy falls at the same edge.
- The nibble add-3 is 4-bit and cannot carry, because a nibble never exceeds 9 before adjust.
- blank_mask: bit i (i >= 1) = 1 iff digits i..DIGITS-1 are all zero. Bit 0 is always 0.
- Output hold: bcd_out, blank_mask and overflow hold their previous values during a conversion and change only at LATCH.
- Handshake boundary cases:
  - start while busy is ignored; no queueing.
  - start asserted in the done cycle (state IDLE) is accepted. Back-to-back conversions therefore run with a period of BIN_W+2 cycles.
  - bin_in changes after acceptance have no effect.
  - start held high continuously gives repeated conversions, each re-sampling bin_in.
- Saturation: bin_in > MAX_VAL converts MAX_VAL (bcd_out = 0x99999999) with overflow = 1. overflow clears on the next in-range conversion.

Test Plan:
- Reset, then idle 5 cycles -> bcd_out = 0x00000000, blank_mask = 8'hFE, busy = 0, done = 0, overflow = 0.
- start with bin_in = 12_345_678 -> busy high cycles 1..28, done pulse exactly 28 cycles after accept, bcd_out = 0x12345678, blank_mask = 8'h00.
- bin_in = 905 -> bcd_out = 0x00000905, blank_mask = 8'hF8. Then bin_in = 0 -> bcd_out = 0, blank_mask = 8'hFE.
- bin_in = 99_999_999 -> 0x99999999, overflow = 0. Then bin_in = 100_000_000 -> 0x99999999, overflow = 1. Then bin_in = 7 -> 0x00000007, blank_mask = 8'hFE, overflow = 0.
- Pulse start with bin_in = 42 at cycle 10 of a conversion of 1234 -> ignored; result is 0x00001234. Then start in the done cycle with bin_in = 42 -> accepted; next done gives 0x00000042.
- Drive rst_n = 0 for 1 cycle at shift 15 of a conversion -> next cycle busy = 0, bcd_out = 0, blank_mask = 8'hFE. No done pulse follows unless a new start is issued.
